// File: rtl/servo_pkg.sv
// Shared types and constants for the servo ramp controller.
package servo_pkg;

  localparam int POS_W = 15;
  localparam logic [POS_W-1:0] POS_CENTER = 15'd16384;

  typedef enum logic {
    IDLE   = 1'b0,
    UPDATE = 1'b1
  } state_t;

  // Index width for a counter over n items; never narrower than one bit.
  function automatic int idx_width(input int n);
    idx_width = (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/servo_step.sv
// Single-channel slew step: moves pos toward target by at most STEP.
module servo_step
  import servo_pkg::*;
#(
  parameter int STEP = 512
) (
  input  logic [POS_W-1:0] i_pos,
  input  logic [POS_W-1:0] i_target,
  output logic [POS_W-1:0] o_next_pos
);

  localparam logic signed [15:0] STEP_S = 16'(STEP);

  logic signed [15:0] w_d;
  logic signed [15:0] w_abs;

  assign w_d = signed'({1'b0, i_target}) - signed'({1'b0, i_pos});

  // Both operands are within [0, 32767], so stepping toward target cannot wrap.
  always_comb begin
    w_abs = w_d[15] ? -w_d : w_d;
    if (w_abs <= STEP_S) begin
      o_next_pos = i_target;
    end else if (w_d[15]) begin
      o_next_pos = i_pos - STEP_S[POS_W-1:0];
    end else begin
      o_next_pos = i_pos + STEP_S[POS_W-1:0];
    end
  end

endmodule

// File: rtl/servo_ramp_ctrl.sv
// Multi-channel servo position scheduler with one shared step engine per frame.
// Optional target clamping to [POS_MIN, POS_MAX] is enabled by SERVO_LIMIT_EN.
module servo_ramp_ctrl
  import servo_pkg::*;
#(
  parameter int CH          = 5,
  parameter int FRAME_TICKS = 1_000_000,
  parameter int STEP        = 512,
  parameter int POS_MIN     = 0,
  parameter int POS_MAX     = 32767
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [2:0]          cmd_ch,
  input  logic [POS_W-1:0]    cmd_pos,
  output logic                cmd_err,
  output logic [CH*POS_W-1:0] pos_out,
  output logic [CH-1:0]       busy,
  output logic                frame_tick
);

  localparam int IW    = idx_width(CH);
  localparam int CNT_W = idx_width(FRAME_TICKS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_TICKS - 1);
  localparam logic [IW-1:0]    IDX_LAST = IW'(CH - 1);
  localparam logic [3:0]       CH_L     = 4'(CH);

`ifdef SERVO_LIMIT_EN
  localparam logic [POS_W-1:0] P_MIN = POS_W'(POS_MIN);
  localparam logic [POS_W-1:0] P_MAX = POS_W'(POS_MAX);
  localparam logic [POS_W-1:0] RST_POS = (POS_CENTER < P_MIN) ? P_MIN :
                                         (POS_CENTER > P_MAX) ? P_MAX : POS_CENTER;
`else
  localparam logic [POS_W-1:0] RST_POS = POS_CENTER;
`endif

  state_t           r_state;
  state_t           w_state_nxt;
  logic [IW-1:0]    r_idx;
  logic [IW-1:0]    w_idx_nxt;
  logic             w_upd;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_tick;
  logic             r_cmd_err;
  logic             w_accept;
  logic             w_ch_ok;
  logic [POS_W-1:0] w_cmd_pos;
  logic [POS_W-1:0] w_sel_pos;
  logic [POS_W-1:0] w_sel_target;
  logic [POS_W-1:0] w_next_pos;
  logic [POS_W-1:0] r_pos    [CH];
  logic [POS_W-1:0] r_target [CH];

  assign cmd_ready  = (r_state == IDLE);
  assign cmd_err    = r_cmd_err;
  assign frame_tick = r_tick;
  assign w_accept   = cmd_valid && cmd_ready;
  assign w_ch_ok    = ({1'b0, cmd_ch} < CH_L);
  assign w_cnt_nxt  = (r_cnt == CNT_LAST) ? '0 : r_cnt + 1'b1;

  // Target conditioning before storage.
  always_comb begin
`ifdef SERVO_LIMIT_EN
    if (cmd_pos < P_MIN) begin
      w_cmd_pos = P_MIN;
    end else if (cmd_pos > P_MAX) begin
      w_cmd_pos = P_MAX;
    end else begin
      w_cmd_pos = cmd_pos;
    end
`else
    w_cmd_pos = cmd_pos;
`endif
  end

  // Frame counter and tick; the tick is registered one cycle ahead of the wrap.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else begin
      r_cnt  <= w_cnt_nxt;
      r_tick <= (w_cnt_nxt == CNT_LAST);
    end
  end

  // FSM state register.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_state <= IDLE;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  // FSM next state: one channel per UPDATE cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_upd       = 1'b0;
    case (r_state)
      IDLE: begin
        if (r_tick) begin
          w_state_nxt = UPDATE;
          w_idx_nxt   = '0;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      UPDATE: begin
        w_upd = 1'b1;
        if (r_idx == IDX_LAST) begin
          w_state_nxt = IDLE;
          w_idx_nxt   = '0;
        end else begin
          w_idx_nxt = r_idx + 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_idx_nxt   = '0;
      end
    endcase
  end

  // Channel multiplexer feeding the shared step engine.
  always_comb begin
    w_sel_pos    = r_pos[0];
    w_sel_target = r_target[0];
    for (int i = 1; i < CH; i++) begin
      if (r_idx == IW'(i)) begin
        w_sel_pos    = r_pos[i];
        w_sel_target = r_target[i];
      end else begin
        w_sel_pos    = w_sel_pos;
        w_sel_target = w_sel_target;
      end
    end
  end

  servo_step #(
    .STEP(STEP)
  ) u_step (
    .i_pos     (w_sel_pos),
    .i_target  (w_sel_target),
    .o_next_pos(w_next_pos)
  );

  // Target/position storage and the invalid-channel error pulse.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_cmd_err <= 1'b0;
      for (int i = 0; i < CH; i++) begin
        r_pos[i]    <= RST_POS;
        r_target[i] <= RST_POS;
      end
    end else begin
      r_cmd_err <= w_accept && !w_ch_ok;
      for (int i = 0; i < CH; i++) begin
        if (w_accept && (cmd_ch == 3'(i))) begin
          r_target[i] <= w_cmd_pos;
        end
        if (w_upd && (r_idx == IW'(i))) begin
          r_pos[i] <= w_next_pos;
        end
      end
    end
  end

  for (genvar g = 0; g < CH; g++) begin : g_out
    assign pos_out[g*POS_W +: POS_W] = r_pos[g];
    assign busy[g]                   = (r_pos[g] != r_target[g]);
  end

endmodule

// File: tb/tb_servo_ramp_ctrl.sv
// Directed self-checking bench for servo_ramp_ctrl (CH=5, FRAME_TICKS=100, STEP=512).
module tb_servo_ramp_ctrl;

  localparam int CH = 5;
  localparam int FT = 100;

  logic          CLK = 1'b0;
  logic          RST_N;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [2:0]    cmd_ch;
  logic [14:0]   cmd_pos;
  logic          cmd_err;
  logic [74:0]   pos_out;
  logic [CH-1:0] busy;
  logic          frame_tick;

  int n_checks = 0;
  int n_errors = 0;

  servo_ramp_ctrl #(
    .CH(CH), .FRAME_TICKS(FT), .STEP(512), .POS_MIN(0), .POS_MAX(25000)
  ) dut (
    .CLK(CLK), .RST_N(RST_N), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_ch(cmd_ch), .cmd_pos(cmd_pos), .cmd_err(cmd_err), .pos_out(pos_out),
    .busy(busy), .frame_tick(frame_tick)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [14:0] pos_of(input int i);
    pos_of = pos_out[i*15 +: 15];
  endfunction

  // Advance negedge by negedge until frame_tick is seen, bounded.
  task automatic wait_tick(output int n);
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (!frame_tick && n < 300);
    chk("tick_seen", {79'd0, frame_tick}, 80'd1);
  endtask

  task automatic send(input logic [2:0] ch, input logic [14:0] p);
    cmd_valid = 1'b1;
    cmd_ch    = ch;
    cmd_pos   = p;
    @(negedge CLK);
    cmd_valid = 1'b0;
  endtask

  initial begin
    int n;
    int stalls;
    logic [74:0] snap_pos;
    logic [CH-1:0] snap_busy;
    logic [74:0] all_ctr;
    logic [14:0] exp_pos;
    for (int i = 0; i < CH; i++) all_ctr[i*15 +: 15] = 15'd16384;

    RST_N = 1'b0; cmd_valid = 1'b0; cmd_ch = 3'd0; cmd_pos = 15'd0;
    repeat (3) @(negedge CLK);
    RST_N = 1'b1;
    chk("rst_pos", {5'd0, pos_out}, {5'd0, all_ctr});
    chk("rst_busy", {75'd0, busy}, 80'd0);
    chk("rst_ready", {79'd0, cmd_ready}, 80'd1);
    chk("rst_err", {79'd0, cmd_err}, 80'd0);
    chk("rst_tick", {79'd0, frame_tick}, 80'd0);
    wait_tick(n);
    chk("first_tick_lat", 80'(n), 80'd99);

    // Slew ch2 up to 20000.
    repeat (10) @(negedge CLK);
    send(3'd2, 15'd20000);
    chk("slew_busy_set", {79'd0, busy[2]}, 80'd1);
    chk("slew_err_none", {79'd0, cmd_err}, 80'd0);
    for (int f = 1; f <= 8; f++) begin
      wait_tick(n);
      repeat (3) @(negedge CLK);
      if (f == 8) chk("slew_busy_last", {79'd0, busy[2]}, 80'd1);
      @(negedge CLK);
      exp_pos = (f < 8) ? 15'(16384 + 512 * f) : 15'd20000;
      chk("slew_pos2", {65'd0, pos_of(2)}, {65'd0, exp_pos});
      if (f == 8) chk("slew_busy_clr", {79'd0, busy[2]}, 80'd0);
    end
    chk("slew_pos0_idle", {65'd0, pos_of(0)}, 80'd16384);

    // Command in the frame_tick cycle is used in the same frame.
    wait_tick(n);
    chk("coll_ready_T", {79'd0, cmd_ready}, 80'd1);
    send(3'd0, 15'd0);
    chk("coll_ready_T1", {79'd0, cmd_ready}, 80'd0);
    @(negedge CLK);
    chk("coll_pos0", {65'd0, pos_of(0)}, 80'd15872);
    repeat (3) @(negedge CLK);
    chk("coll_ready_T5", {79'd0, cmd_ready}, 80'd0);
    @(negedge CLK);
    chk("coll_ready_T6", {79'd0, cmd_ready}, 80'd1);

    // Command held across UPDATE stalls until IDLE.
    wait_tick(n);
    @(negedge CLK);
    cmd_valid = 1'b1; cmd_ch = 3'd1; cmd_pos = 15'd10000;
    stalls = 0;
    while (!cmd_ready && stalls < 20) begin
      @(negedge CLK);
      stalls++;
    end
    chk("hold_stalls", 80'(stalls), 80'd5);
    @(negedge CLK);
    cmd_valid = 1'b0;
    chk("hold_busy1", {79'd0, busy[1]}, 80'd1);

    // Invalid channel: consumed, error pulse, no state change.
    repeat (5) @(negedge CLK);
    snap_pos = pos_out; snap_busy = busy;
    send(3'd6, 15'd123);
    chk("inv_err_pulse", {79'd0, cmd_err}, 80'd1);
    @(negedge CLK);
    chk("inv_err_clr", {79'd0, cmd_err}, 80'd0);
    chk("inv_pos", {5'd0, pos_out}, {5'd0, snap_pos});
    chk("inv_busy", {75'd0, busy}, {75'd0, snap_busy});

    // Reset in the middle of an UPDATE sweep.
    wait_tick(n);
    repeat (3) @(negedge CLK);
    RST_N = 1'b0;
    @(negedge CLK);
    RST_N = 1'b1;
    chk("mid_rst_pos", {5'd0, pos_out}, {5'd0, all_ctr});
    chk("mid_rst_busy", {75'd0, busy}, 80'd0);
    chk("mid_rst_ready", {79'd0, cmd_ready}, 80'd1);
    wait_tick(n);
    chk("mid_rst_tick_lat", 80'(n), 80'd99);

    // Large move on ch3; settles at the clamp when limits are enabled.
    repeat (10) @(negedge CLK);
    send(3'd3, 15'd30000);
    for (int f = 0; f < 30; f++) wait_tick(n);
    repeat (4) @(negedge CLK);
`ifdef SERVO_LIMIT_EN
    chk("settle_pos3", {65'd0, pos_of(3)}, 80'd25000);
`else
    chk("settle_pos3", {65'd0, pos_of(3)}, 80'd30000);
`endif
    chk("settle_busy", {75'd0, busy}, 80'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
